// File: rtl/ro_multi_channel_memory_map_if.sv
// ro_multi_channel_memory_map_if: host MMIO bus; the user modport is the register-file side.
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
  modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/ro_multi_channel_memory_map.sv
// ro_multi_channel_memory_map: MMIO register file driving NUM_CH ring-oscillator sampler channels.
// Ports: clk/rst (sync, active-high); mmio (host register bus, 1-cycle read latency);
// rd_addr/wr_addr/num_samples/collect_cycles (per-channel config, channel c at [c*W +: W]);
// go (one-cycle start pulse), busy (channel running), done_in (one-cycle completion pulse).
module ro_multi_channel_memory_map #(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0050,
  parameter logic [15:0] CH_STRIDE  = 16'h0010,
  parameter logic [63:0] VERSION    = 64'h0000_0002_0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  mmio_if.user                         mmio,
  output logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CH*SIZE_WIDTH-1:0] num_samples,
  output logic [NUM_CH*SIZE_WIDTH-1:0] collect_cycles,
  output logic [NUM_CH-1:0]            go,
  output logic [NUM_CH-1:0]            busy,
  input  logic [NUM_CH-1:0]            done_in
);
  localparam logic [15:0] A_GO   = BASE_ADDR;
  localparam logic [15:0] A_DONE = BASE_ADDR + 16'd2;
  localparam logic [15:0] A_BUSY = BASE_ADDR + 16'd4;
  localparam logic [15:0] A_ERR  = BASE_ADDR + 16'd6;
  localparam logic [15:0] A_ID   = BASE_ADDR + 16'd8;
  // Banks start past the global block and each needs 8 words; the last must not wrap the 16-bit space.
  if (NUM_CH < 1 || NUM_CH > 16 || CH_STRIDE < 16'd8 ||
      32'(BASE_ADDR) + 32'h10 + NUM_CH * 32'(CH_STRIDE) > 32'h10000) begin : g_bad_map
    $error("ro_multi_channel_memory_map: channel banks overlap or exceed the address space");
  end
  function automatic logic [15:0] cb(input int c, input int k);
    return 16'(32'(BASE_ADDR) + 32'h10 + c * 32'(CH_STRIDE) + k);
  endfunction
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [NUM_CH-1:0][SIZE_WIDTH-1:0] r_num, r_cyc;
  logic [NUM_CH-1:0] r_go, r_busy, r_done, r_err;
  logic [63:0] r_rd_data, w_rd_val;
  logic [NUM_CH-1:0] w_go_req, w_done_clr, w_err_clr, w_start, w_bad, w_fin;
  assign w_go_req   = (mmio.wr_en && mmio.wr_addr == A_GO)   ? mmio.wr_data[NUM_CH-1:0] : '0;
  assign w_done_clr = (mmio.wr_en && mmio.wr_addr == A_DONE) ? mmio.wr_data[NUM_CH-1:0] : '0;
  assign w_err_clr  = (mmio.wr_en && mmio.wr_addr == A_ERR)  ? mmio.wr_data[NUM_CH-1:0] : '0;
  assign w_start = w_go_req & ~r_busy;
  assign w_bad   = w_go_req & r_busy;
  assign w_fin   = done_in & r_busy;
  always_comb begin
    w_rd_val = mmio.rd_addr == A_DONE ? 64'(r_done) :
               mmio.rd_addr == A_BUSY ? 64'(r_busy) :
               mmio.rd_addr == A_ERR  ? 64'(r_err)  :
               mmio.rd_addr == A_ID   ? VERSION     : 64'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mmio.rd_addr == cb(c, 0)) w_rd_val = 64'(r_rd_addr[c]);
      if (mmio.rd_addr == cb(c, 2)) w_rd_val = 64'(r_wr_addr[c]);
      if (mmio.rd_addr == cb(c, 4)) w_rd_val = 64'(r_num[c]);
      if (mmio.rd_addr == cb(c, 6)) w_rd_val = 64'(r_cyc[c]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_num     <= '0;
      r_cyc     <= '0;
      r_go      <= '0;
      r_busy    <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rd_data <= '0;
    end else begin
      r_go   <= w_start;
      r_busy <= (r_busy & ~w_fin) | w_start;
      // Set events override a same-cycle write-1-to-clear.
      r_done <= (r_done & ~w_done_clr & ~w_start) | w_fin;
      r_err  <= (r_err & ~w_err_clr) | w_bad;
      if (mmio.rd_en) r_rd_data <= w_rd_val;
      for (int c = 0; c < NUM_CH; c++) begin
        if (mmio.wr_en && !r_busy[c]) begin
          if (mmio.wr_addr == cb(c, 0)) r_rd_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
          if (mmio.wr_addr == cb(c, 2)) r_wr_addr[c] <= mmio.wr_data[ADDR_WIDTH-1:0];
          if (mmio.wr_addr == cb(c, 4)) r_num[c]     <= mmio.wr_data[SIZE_WIDTH-1:0];
          if (mmio.wr_addr == cb(c, 6)) r_cyc[c]     <= mmio.wr_data[SIZE_WIDTH-1:0];
        end
      end
    end
  end
  assign mmio.rd_data   = r_rd_data;
  assign rd_addr        = r_rd_addr;
  assign wr_addr        = r_wr_addr;
  assign num_samples    = r_num;
  assign collect_cycles = r_cyc;
  assign go             = r_go;
  assign busy           = r_busy;
endmodule

// File: tb/tb_ro_multi_channel_memory_map.sv
// tb_ro_multi_channel_memory_map: scoreboard bench for the multi-channel MMIO register file.
module tb_ro_multi_channel_memory_map;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] done_in;
  logic [255:0] ch_rd_addr, ch_wr_addr;
  logic [127:0] ch_num, ch_cyc;
  logic [3:0] go, busy;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q[$];
  logic [63:0] act, ex;
  localparam logic [15:0] GO = 16'h50, DONE = 16'h52, BUSY = 16'h54, ERR = 16'h56, ID = 16'h58;
  localparam logic [63:0] VER = 64'h0000_0002_0000_0000;
  always #5 clk = ~clk;
  mmio_if u_mmio();
  ro_multi_channel_memory_map dut (
    .clk(clk), .rst(rst), .mmio(u_mmio),
    .rd_addr(ch_rd_addr), .wr_addr(ch_wr_addr), .num_samples(ch_num), .collect_cycles(ch_cyc),
    .go(go), .busy(busy), .done_in(done_in)
  );
  function automatic logic [15:0] cb(input int c, input int k);
    return 16'(32'h60 + c * 32'h10 + k);
  endfunction
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    u_mmio.wr_en = 1'b1; u_mmio.wr_addr = a; u_mmio.wr_data = d;
    tick;
    u_mmio.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [63:0] e, output logic [63:0] got, output logic [63:0] want);
    q.push_back(e);
    u_mmio.rd_en = 1'b1; u_mmio.rd_addr = a;
    tick;
    u_mmio.rd_en = 1'b0;
    got = u_mmio.rd_data;
    want = q.pop_front();
  endtask
  task automatic test_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
    n_vec++; if (go !== 4'b0) begin n_err++; $display("FAIL rst_go got=%b exp=0000", go); end
    n_vec++; if (busy !== 4'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0000", busy); end
    foreach (GO[i]) begin end
    for (int a = 0; a < 5; a++) begin
      rd(16'(32'h50 + 2 * a), a == 4 ? VER : 64'h0, act, ex);
      n_vec++; if (act !== ex) begin n_err++; $display("FAIL rst_global a=%0d got=%h exp=%h", a, act, ex); end
    end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 8; k += 2) begin
        rd(cb(c, k), 64'h0, act, ex);
        n_vec++; if (act !== ex) begin n_err++; $display("FAIL rst_bank c=%0d k=%0d got=%h exp=%h", c, k, act, ex); end
      end
  endtask
  task automatic test_config_start;
    wr(cb(1, 0), 64'h1000);
    wr(cb(1, 2), 64'hDEAD_BEEF_CAFE_F00D);
    wr(cb(1, 4), 64'hFFFF_FFFF_0000_0040);
    wr(GO, 64'h2);
    n_vec++; if (go !== 4'b0010) begin n_err++; $display("FAIL start_go got=%b exp=0010", go); end
    tick;
    n_vec++; if (go !== 4'b0) begin n_err++; $display("FAIL start_go_width got=%b exp=0000", go); end
    n_vec++; if (busy !== 4'b0010) begin n_err++; $display("FAIL start_busy got=%b exp=0010", busy); end
    rd(cb(1, 0), 64'h1000, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL cfg_rd_addr got=%h exp=%h", act, ex); end
    rd(cb(1, 2), 64'hDEAD_BEEF_CAFE_F00D, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL cfg_wr_addr got=%h exp=%h", act, ex); end
    rd(cb(1, 4), 64'h40, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL cfg_num_zext got=%h exp=%h", act, ex); end
    rd(BUSY, 64'h2, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL busy_reg got=%h exp=%h", act, ex); end
    n_vec++; if (ch_rd_addr[64 +: 64] !== 64'h1000) begin n_err++; $display("FAIL out_rd_addr got=%h exp=1000", ch_rd_addr[64 +: 64]); end
    n_vec++; if (ch_num[32 +: 32] !== 32'h40) begin n_err++; $display("FAIL out_num got=%h exp=40", ch_num[32 +: 32]); end
    tick;
    n_vec++; if (u_mmio.rd_data !== 64'h2) begin n_err++; $display("FAIL rd_hold got=%h exp=2", u_mmio.rd_data); end
  endtask
  task automatic test_done_clear;
    done_in = 4'b0010; tick; done_in = 4'b0;
    rd(BUSY, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_busy got=%h exp=%h", act, ex); end
    rd(DONE, 64'h2, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_set got=%h exp=%h", act, ex); end
    wr(DONE, 64'h2);
    rd(DONE, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_w1c got=%h exp=%h", act, ex); end
    wr(GO, 64'h4); tick;
    done_in = 4'b0100; wr(DONE, 64'h4); done_in = 4'b0;
    rd(DONE, 64'h4, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_set_wins got=%h exp=%h", act, ex); end
    done_in = 4'b0001; tick; done_in = 4'b0;
    rd(DONE, 64'h4, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_idle_ignored got=%h exp=%h", act, ex); end
    wr(cb(3, 0), 64'h1111);
    q.push_back(64'h1111);
    u_mmio.rd_en = 1'b1; u_mmio.rd_addr = cb(3, 0);
    u_mmio.wr_en = 1'b1; u_mmio.wr_addr = cb(3, 0); u_mmio.wr_data = 64'h2222;
    tick;
    u_mmio.rd_en = 1'b0; u_mmio.wr_en = 1'b0;
    act = u_mmio.rd_data; ex = q.pop_front();
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL rdwr_old got=%h exp=%h", act, ex); end
    rd(cb(3, 0), 64'h2222, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL rdwr_new got=%h exp=%h", act, ex); end
  endtask
  task automatic test_illegal_lock;
    wr(cb(0, 6), 64'd10);
    wr(GO, 64'h1);
    n_vec++; if (go !== 4'b0001) begin n_err++; $display("FAIL ch0_go got=%b exp=0001", go); end
    wr(GO, 64'h1);
    n_vec++; if (go !== 4'b0) begin n_err++; $display("FAIL illegal_go got=%b exp=0000", go); end
    wr(cb(0, 6), 64'd99);
    rd(cb(0, 6), 64'd10, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL cfg_lock got=%h exp=%h", act, ex); end
    n_vec++; if (ch_cyc[0 +: 32] !== 32'd10) begin n_err++; $display("FAIL out_cyc got=%h exp=a", ch_cyc[0 +: 32]); end
    rd(ERR, 64'h1, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL err_set got=%h exp=%h", act, ex); end
    wr(ERR, 64'h1);
    rd(ERR, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL err_w1c got=%h exp=%h", act, ex); end
    done_in = 4'b0001; wr(GO, 64'h1); done_in = 4'b0;
    n_vec++; if (go !== 4'b0 || busy[0] !== 1'b0) begin n_err++; $display("FAIL done_vs_illegal go=%b busy=%b exp go=0000 busy0=0", go, busy); end
    rd(ERR, 64'h1, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_vs_illegal_err got=%h exp=%h", act, ex); end
    rd(DONE, 64'h5, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL done_vs_illegal_done got=%h exp=%h", act, ex); end
    wr(ERR, 64'h1);
  endtask
  task automatic test_multi_unmapped;
    wr(GO, 64'hFFFF);
    n_vec++; if (go !== 4'b1111) begin n_err++; $display("FAIL multi_go got=%b exp=1111", go); end
    tick;
    n_vec++; if (go !== 4'b0) begin n_err++; $display("FAIL multi_go_width got=%b exp=0000", go); end
    rd(16'h00A0, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL unmapped_bank got=%h exp=%h", act, ex); end
    rd(GO, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL go_reads_zero got=%h exp=%h", act, ex); end
    rd(16'h005A, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL unmapped_global got=%h exp=%h", act, ex); end
    rd(BUSY, 64'hF, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL multi_busy got=%h exp=%h", act, ex); end
    rd(DONE, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL start_clears_done got=%h exp=%h", act, ex); end
  endtask
  task automatic test_mid_reset;
    done_in = 4'b0111; tick; done_in = 4'b0;
    n_vec++; if (busy !== 4'b1000) begin n_err++; $display("FAIL ch3_busy got=%b exp=1000", busy); end
    rst = 1'b1; tick; rst = 1'b0;
    n_vec++; if (busy !== 4'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0000", busy); end
    done_in = 4'b1000; tick; done_in = 4'b0;
    rd(BUSY, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL post_rst_busy got=%h exp=%h", act, ex); end
    rd(DONE, 64'h0, act, ex);
    n_vec++; if (act !== ex) begin n_err++; $display("FAIL post_rst_done got=%h exp=%h", act, ex); end
    rst = 1'b1; wr(GO, 64'h1); rst = 1'b0;
    n_vec++; if (go !== 4'b0 || busy !== 4'b0) begin n_err++; $display("FAIL rst_suppress go=%b busy=%b exp 0000", go, busy); end
  endtask
  initial begin
    rst = 1'b1; done_in = 4'b0;
    u_mmio.wr_en = 1'b0; u_mmio.wr_addr = '0; u_mmio.wr_data = '0;
    u_mmio.rd_en = 1'b0; u_mmio.rd_addr = '0;
    tick;
    test_reset;
    test_config_start;
    test_done_clear;
    test_illegal_lock;
    test_multi_unmapped;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ro_multi_channel_memory_map.md
Name: ro_multi_channel_memory_map

Overview:
Parametrised MMIO register file that controls NUM_CH independent ring-oscillator sampling channels from host software. Each channel has its own DMA read/write addresses, sample count and collection-cycle count. The block issues a go pulse per channel, tracks busy state, and latches done events into sticky status bits that software clears by writing 1. Config registers are write-locked while a channel is busy, and illegal starts are flagged. It sits between the mmio_if.user port of the AFU and the per-channel sampler/DMA engines.

Parameters:
NUM_CH, 4, number of channels (1..16).
ADDR_WIDTH, 64, width of DMA byte addresses.
SIZE_WIDTH, 32, width of num_samples and collect_cycles.
BASE_ADDR, 16'h0050, MMIO address of the first global register.
CH_STRIDE, 16'h0010, MMIO address spacing between channel register banks.
VERSION, 64'h0000_0002_0000_0000, constant returned by the ID register.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mmio  mmio_if.user  -  wr_en, wr_addr[15:0], wr_data[63:0], rd_en, rd_addr[15:0], rd_data[63:0]
rd_addr  out  NUM_CH*ADDR_WIDTH  per-channel DMA read address; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
wr_addr  out  NUM_CH*ADDR_WIDTH  per-channel DMA write address
num_samples  out  NUM_CH*SIZE_WIDTH  per-channel cache-line count
collect_cycles  out  NUM_CH*SIZE_WIDTH  per-channel sampling window
go  out  NUM_CH  one-cycle start pulse per channel
busy  out  NUM_CH  channel running
done_in  in  NUM_CH  one-cycle completion pulse from each channel

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). On reset, every output, every register and mmio.rd_data go to 0.
- Global register map (word addresses):
  - BASE+0 GO (write-only; reads return 0).
  - BASE+2 DONE (sticky; W1C).
  - BASE+4 BUSY (read-only).
  - BASE+6 ERR (sticky; W1C).
  - BASE+8 ID (reads VERSION).
- Channel c register bank base is CB = BASE_ADDR + 16'h0010 + c*CH_STRIDE:
  - CB+0 rd_addr.
  - CB+2 wr_addr.
  - CB+4 num_samples.
  - CB+6 collect_cycles.
  - Each is R/W, written from wr_data LSBs and read back zero-extended.
- Config writes to channel c are ignored while busy[c]=1. Reads are always allowed.
- GO write, wr_data bit c set, busy[c]=0 (start accepted):
  - go[c]=1 on the next cycle, for exactly 1 cycle.
  - busy[c]=1 and DONE[c] cleared on the same edge.
- GO write, bit c set, busy[c]=1 (illegal start): no go pulse; ERR[c] is set.
- GO bits at index >= NUM_CH are ignored. One write may start several channels in the same cycle.
- done_in[c]=1 while busy[c]=1: busy[c]=0 and DONE[c]=1 on the next edge.
- done_in[c]=1 while busy[c]=0 is ignored.
- W1C on DONE or ERR in the same cycle as a set event: the set wins.
- done_in[c] and an accepted GO for channel c in the same cycle cannot occur, because GO requires busy[c]=0. If done_in and an illegal GO coincide, done is processed and ERR[c] is set.
- Reads:
  - When rd_en=1, rd_data is updated on the next edge, giving 1-cycle latency.
  - Unmapped addresses, including channel banks with c >= NUM_CH, return 64'h0.
  - rd_data holds its value when rd_en=0.
- Simultaneous rd_en and wr_en to the same register: the read returns the old value.
- Register updates from write decode take effect on the edge following wr_en.
- Reset mid-operation clears busy, DONE and ERR and suppresses any pending go pulse. Any done_in arriving after reset is ignored.
- NUM_CH*CH_STRIDE must not overlap the global block. This is checked by an elaboration assertion.

Test Plan:
1. Reset and readback: assert rst 2 cycles, then read every mapped address -> all 0 except ID = VERSION; go=0, busy=0.
2. Config and start, defaults: write ch1 rd_addr=64'h1000, num_samples=32'd64, then GO=4'b0010 -> readbacks match; go=4'b0010 for exactly 1 cycle; BUSY reads 4'b0010.
3. Completion and clear: pulse done_in[1] -> BUSY=0, DONE=4'b0010. Write DONE=4'b0010 -> DONE=0. Coincident done_in[2] with W1C of bit 2 -> DONE[2]=1.
4. Illegal restart and lock: while ch0 is busy, write GO=4'b0001 and ch0 collect_cycles=32'd99 -> no go pulse, ERR=4'b0001, collect_cycles keeps its old value. Write ERR=1 -> ERR=0.
5. Multi-start and unmapped read, defaults: GO=64'hFFFF -> go=4'b1111 once. Read bank address BASE+16'h0010+4*CH_STRIDE -> 0.
6. Mid-run reset: while ch3 is busy, assert rst for 1 cycle, then pulse done_in[3] -> BUSY=0, DONE=0.
